// File: rtl/polyvec_matrix_pointwise_stream.sv
// -----------------------------------------------------------------------------
// polyvec_matrix_pointwise_stream
//
// Streams a KxL matrix of polynomials A against an L-vector of polynomials v
// and writes t[k][n] = sum_l montgomery_reduce(A[k][l][n] * v[l][n]).
// Reads are issued one pair per cycle (k outer, n middle, l inner); each term
// goes through data capture, a registered 64-bit product, a registered
// Montgomery reduction and finally accumulate-and-write.
//
// Optional build macro: MATVEC_REDUCE32_EN
//   defined   -> t_wdata = reduce32(S) on the accumulated sum S
//   undefined -> t_wdata = S
//
// Ports
//   clock      in   posedge clock
//   reset      in   synchronous, active-high reset
//   rtr        in   request to run, level-held until rts
//   rts        out  result complete, held until rtr drops
//   mat_addr   out  A read address (k*L+l)*N+n, 0 outside RUN
//   mat_rdata  in   A coefficient, one cycle after mat_addr
//   vec_addr   out  v read address l*N+n, 0 outside RUN
//   vec_rdata  in   v coefficient, one cycle after vec_addr
//   t_we       out  result write strobe
//   t_addr     out  result address k*N+n
//   t_wdata    out  result coefficient
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | post-reset / post-handshake, moves on next cycle
// WAIT_RTR | waiting for rtr to be sampled high
// RUN      | issuing K*L*N read pairs, one per cycle
// DRAIN    | pipeline emptying until the final write
// DONE     | rts high until rtr drops
// -----------------------------------------------------------------------------
module polyvec_matrix_pointwise_stream #(
    parameter int K = 6,
    parameter int L = 5,
    parameter int N = 256,
    localparam int MA_W = $clog2(K * L * N),
    localparam int VA_W = $clog2(L * N),
    localparam int TA_W = $clog2(K * N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rtr,
    output logic                   rts,
    output logic [MA_W-1:0]        mat_addr,
    input  logic signed [31:0]     mat_rdata,
    output logic [VA_W-1:0]        vec_addr,
    input  logic signed [31:0]     vec_rdata,
    output logic                   t_we,
    output logic [TA_W-1:0]        t_addr,
    output logic signed [31:0]     t_wdata
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RTR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Per-term tag that travels alongside the data through the pipeline.
    typedef struct packed {
        logic            valid;
        logic            first;   // l == 0: accumulator restarts
        logic            last_l;  // l == L-1: this term completes a (k,n)
        logic            fin;     // very last term of the operation
        logic [TA_W-1:0] taddr;
    } meta_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [KW-1:0]         r_k;
    logic [LW-1:0]         r_l;
    logic [NW-1:0]         r_n;
    logic                  w_run;
    logic                  w_issue_last;
    meta_t                 w_meta0;
    meta_t                 r_meta1;
    meta_t                 r_meta2;
    meta_t                 r_meta3;
    logic signed [63:0]    r_prod;
    logic signed [31:0]    r_mont;
    logic signed [31:0]    r_acc;
    logic signed [31:0]    w_qt;
    logic signed [63:0]    w_qtq;
    logic signed [63:0]    w_diff;
    logic signed [31:0]    w_sum;
    logic signed [31:0]    w_out;
    logic                  w_write;
    logic                  r_t_we;
    logic [TA_W-1:0]       r_t_addr;
    logic signed [31:0]    r_t_wdata;
    logic                  r_wr_final;

    assign w_run        = (r_state == S_RUN);
    assign w_issue_last = w_run && (r_k == KW'(K - 1)) && (r_n == NW'(N - 1))
                          && (r_l == LW'(L - 1));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     w_state_next = S_WAIT_RTR;
            S_WAIT_RTR: if (rtr) w_state_next = S_RUN;
            S_RUN:      if (w_issue_last) w_state_next = S_DRAIN;
            S_DRAIN:    if (r_wr_final) w_state_next = S_DONE;
            S_DONE:     if (!rtr) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Index counters sit at zero outside RUN so every run starts at (0,0,0).
    always_ff @(posedge clock) begin
        if (reset || !w_run) begin
            r_k <= '0;
            r_n <= '0;
            r_l <= '0;
        end else if (r_l == LW'(L - 1)) begin
            r_l <= '0;
            if (r_n == NW'(N - 1)) begin
                r_n <= '0;
                r_k <= (r_k == KW'(K - 1)) ? '0 : r_k + KW'(1);
            end else begin
                r_n <= r_n + NW'(1);
            end
        end else begin
            r_l <= r_l + LW'(1);
        end
    end

    assign mat_addr = w_run ? MA_W'((32'(r_k) * 32'(L) + 32'(r_l)) * 32'(N) + 32'(r_n)) : '0;
    assign vec_addr = w_run ? VA_W'(32'(r_l) * 32'(N) + 32'(r_n)) : '0;

    always_comb begin
        w_meta0        = '0;
        w_meta0.valid  = w_run;
        w_meta0.first  = (r_l == '0);
        w_meta0.last_l = (r_l == LW'(L - 1));
        w_meta0.fin    = w_issue_last;
        w_meta0.taddr  = TA_W'(32'(r_k) * 32'(N) + 32'(r_n));
    end

    // Montgomery: only the low 32 bits of prod*QINV matter, so that multiply
    // stays 32 bits wide; the subtraction clears the low word exactly.
    assign w_qt   = r_prod[31:0] * 32'sd58728449;
    assign w_qtq  = 64'(w_qt) * 64'sd8380417;
    assign w_diff = r_prod - w_qtq;

    assign w_sum   = r_meta3.first ? r_mont : r_acc + r_mont;
    assign w_write = r_meta3.valid && r_meta3.last_l;

`ifdef MATVEC_REDUCE32_EN
    assign w_out = w_sum - ((w_sum + 32'sd4194304) >>> 23) * 32'sd8380417;
`else
    assign w_out = w_sum;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta1    <= '0;
            r_meta2    <= '0;
            r_meta3    <= '0;
            r_prod     <= '0;
            r_mont     <= '0;
            r_acc      <= '0;
            r_t_we     <= 1'b0;
            r_t_addr   <= '0;
            r_t_wdata  <= '0;
            r_wr_final <= 1'b0;
        end else begin
            r_meta1    <= w_meta0;
            r_meta2    <= r_meta1;
            r_meta3    <= r_meta2;
            r_prod     <= 64'(mat_rdata) * 64'(vec_rdata);
            r_mont     <= 32'(w_diff >>> 32);
            if (r_meta3.valid) r_acc <= w_sum;
            r_t_we     <= w_write;
            r_t_addr   <= w_write ? r_meta3.taddr : '0;
            r_t_wdata  <= w_write ? w_out : '0;
            r_wr_final <= r_meta3.valid && r_meta3.fin;
        end
    end

    assign t_we    = r_t_we;
    assign t_addr  = r_t_addr;
    assign t_wdata = r_t_wdata;
    assign rts     = (r_state == S_DONE);

endmodule
